// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the param_fifo block.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;

    // LEVELo has to represent 0..depth inclusive, hence one bit more than the address.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for param_fifo: synchronous write, asynchronous read, no reset on the array.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with level/threshold flags and sticky overflow/underflow.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                                  CLKip,
    input  logic                                  RSTi,
    input  logic                                  CLRi,
    input  logic                                  WEi,
    input  logic [DATA_WIDTH-1:0]                 DATAi,
    input  logic                                  RDi,
    output logic [DATA_WIDTH-1:0]                 DATAo,
    output logic                                  VALIDo,
    output logic                                  FULLo,
    output logic                                  AFULLo,
    output logic                                  EMPTYo,
    output logic                                  AEMPTYo,
    output logic [level_width(FIFO_DEPTH)-1:0]    LEVELo,
    output logic                                  OVFo,
    output logic                                  UDFo
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = level_width(FIFO_DEPTH);

    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("param_fifo: FIFO_DEPTH must be a power of 2 and >= 4");
    end
    if (AEMPTY_THRESH >= AFULL_THRESH) begin : g_bad_thresh
        $error("param_fifo: AEMPTY_THRESH must be below AFULL_THRESH");
    end

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full, empty, wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Flags come from the registered level only, so a full FIFO rejects a write
    // even when a read frees a slot in the same cycle (and symmetrically when empty).
    assign full   = (level_q == LW'(FIFO_DEPTH));
    assign empty  = (level_q == '0);
    assign wr_acc = WEi && !full && !CLRi;
    assign rd_acc = RDi && !empty && !CLRi;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (CLRi) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (WEi && full)  ovf_d = 1'b1;
            if (RDi && empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge CLKip or negedge RSTi) begin
        if (!RSTi) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (CLKip),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (DATAi),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Read handshake: RDi is a request, accepted only when !EMPTYo; VALIDo qualifies DATAo
    // (a one-cycle strobe after an accepted read, or level-style "head word present" in FWFT).
`ifdef FIFO_FWFT_EN
    assign DATAo  = empty ? '0 : ram_rdata;
    assign VALIDo = !empty;
`else
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (rd_acc) begin
            data_d  = ram_rdata;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLKip or negedge RSTi) begin
        if (!RSTi) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign DATAo  = data_q;
    assign VALIDo = valid_q;
`endif

    assign LEVELo  = level_q;
    assign FULLo   = full;
    assign EMPTYo  = empty;
    assign AFULLo  = (level_q >= LW'(AFULL_THRESH));
    assign AEMPTYo = (level_q <= LW'(AEMPTY_THRESH));
    assign OVFo    = ovf_q;
    assign UDFo    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo (default parameters); build with or without FIFO_FWFT_EN.
module tb_param_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam int AF_TH = 14;
    localparam int AE_TH = 2;

    // clock / reset / inputs
    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          clr   = 1'b0;
    logic          we    = 1'b0;
    logic          rd    = 1'b0;
    logic [DW-1:0] din   = '0;

    logic [DW-1:0] dout;
    logic          valid, full, afull, empty, aempty, ovf, udf;
    logic [LW-1:0] level;

    param_fifo dut (
        .CLKip   (clk),
        .RSTi    (rst_n),
        .CLRi    (clr),
        .WEi     (we),
        .DATAi   (din),
        .RDi     (rd),
        .DATAo   (dout),
        .VALIDo  (valid),
        .FULLo   (full),
        .AFULLo  (afull),
        .EMPTYo  (empty),
        .AEMPTYo (aempty),
        .LEVELo  (level),
        .OVFo    (ovf),
        .UDFo    (udf)
    );

    always #5 clk = ~clk;

    // scoreboard / reference model
    int            total = 0;
    int            bad   = 0;
    string         phase = "reset";
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_q[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
`ifndef FIFO_FWFT_EN
    logic [DW-1:0] last_data = '0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = model_q.size();
        chk({phase, ".level"},  32'(level),  32'(n));
        chk({phase, ".full"},   32'(full),   32'(n == DEPTH));
        chk({phase, ".empty"},  32'(empty),  32'(n == 0));
        chk({phase, ".afull"},  32'(afull),  32'(n >= AF_TH));
        chk({phase, ".aempty"}, 32'(aempty), 32'(n <= AE_TH));
        chk({phase, ".ovf"},    32'(ovf),    32'(m_ovf));
        chk({phase, ".udf"},    32'(udf),    32'(m_udf));
`ifdef FIFO_FWFT_EN
        chk({phase, ".fwft_valid"}, 32'(valid), 32'(n != 0));
        if (n != 0) chk({phase, ".fwft_head"}, 32'(dout), 32'(model_q[0]));
`endif
    endtask

    // driver: called at posedge+1, checks the current state then issues one cycle
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        bit full_m, empty_m;
        check_state();
        full_m  = (model_q.size() == DEPTH);
        empty_m = (model_q.size() == 0);
        if (c) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && !empty_m) exp_q.push_back(model_q.pop_front());
            if (w && !full_m)  model_q.push_back(d);
            if (w && full_m)   m_ovf = 1'b1;
            if (r && empty_m)  m_udf = 1'b1;
        end
        we  = w;
        din = d;
        rd  = r;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".dout"},   32'(dout),   32'h0);
        chk({tag, ".valid"},  32'(valid),  32'h0);
        chk({tag, ".level"},  32'(level),  32'h0);
        chk({tag, ".empty"},  32'(empty),  32'h1);
        chk({tag, ".aempty"}, 32'(aempty), 32'h1);
        chk({tag, ".full"},   32'(full),   32'h0);
        chk({tag, ".afull"},  32'(afull),  32'h0);
        chk({tag, ".ovf"},    32'(ovf),    32'h0);
        chk({tag, ".udf"},    32'(udf),    32'h0);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents read data
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef FIFO_FWFT_EN
            if (rd && !clr && valid) begin
                if (exp_q.size() == 0) chk("sb.read_without_expect", 32'(valid), 32'h0);
                else                   chk("sb.data", 32'(dout), 32'(exp_q.pop_front()));
            end
`else
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb.valid_without_read", 32'(valid), 32'h0);
                end else begin
                    last_data = exp_q.pop_front();
                    chk("sb.data", 32'(dout), 32'(last_data));
                end
            end else begin
                chk("sb.hold", 32'(dout), 32'(last_data));
            end
`endif
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        phase = "fill";
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        phase = "drain";
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

        phase = "ovf";
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        phase = "udf";
        step(1'b1, 8'h5C, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        phase = "steady";
        for (int i = 0; i < 8; i++)  step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  step(1'b0, '0, 1'b1, 1'b0);

        phase = "thresh";
        for (int i = 0; i < AF_TH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < AF_TH; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        phase = "midreset";
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, DW'($urandom), 1'b1, 1'b0);
        step(1'b1, DW'($urandom), 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("midreset.async");
        model_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
`ifndef FIFO_FWFT_EN
        last_data = '0;
`endif
        we  = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("midreset.held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        phase = "postreset";
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 199) == 0);
        end

        phase = "final";
        for (int i = 0; i <= DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("sb.leftover", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entry count, power of 2, >= 4.
REQ-003 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-2, level at or above which AFULLo asserts.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2, level at or below which AEMPTYo asserts.
REQ-005 SHALL have port CLKip  in  1  single clock, all logic rising-edge.
REQ-006 SHALL have port RSTi  in  1  asynchronous active-low reset.
REQ-007 SHALL have port CLRi  in  1  synchronous flush, active high.
REQ-008 SHALL have port WEi  in  1  write request.
REQ-009 SHALL have port DATAi  in  DATA_WIDTH  write data.
REQ-010 SHALL have port RDi  in  1  read request.
REQ-011 SHALL have port DATAo  out  DATA_WIDTH  read data.
REQ-012 SHALL have port VALIDo  out  1  DATAo valid qualifier.
REQ-013 SHALL have ports FULLo, AFULLo, EMPTYo, AEMPTYo  out  1 each  status flags.
REQ-014 SHALL have port LEVELo  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
REQ-015 SHALL have ports OVFo, UDFo  out  1 each  sticky overflow/underflow.

Function
REQ-016 Write accepted iff WEi && !FULLo; DATAi stored at write pointer; pointer wraps FIFO_DEPTH-1 -> 0.
REQ-017 Read accepted iff RDi && !EMPTYo; read pointer wraps FIFO_DEPTH-1 -> 0.
REQ-018 LEVELo: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write+read; updated at the clock edge.
REQ-019 FULLo = (LEVELo == FIFO_DEPTH); EMPTYo = (LEVELo == 0); both derived from registered LEVELo only.
REQ-020 When full, a write is rejected even if a read is accepted in the same cycle; the read completes.
REQ-021 When empty, a read is rejected even if a write is accepted in the same cycle; the write completes.
REQ-022 AFULLo = (LEVELo >= AFULL_THRESH); AEMPTYo = (LEVELo <= AEMPTY_THRESH).
REQ-023 OVFo sets on the cycle after WEi && FULLo, and stays set until CLRi or reset.
REQ-024 UDFo sets on the cycle after RDi && EMPTYo, and stays set until CLRi or reset.
REQ-025 CLRi overrides WEi/RDi: pointers, LEVELo, OVFo, UDFo and VALIDo go to 0 at the next edge; memory contents are not cleared.
REQ-026 Standard mode: DATAo is registered and loaded with the head word one cycle after an accepted read.
REQ-027 Standard mode: VALIDo is high for exactly that one cycle; DATAo holds its value otherwise.
REQ-028 FWFT mode: DATAo presents the head word whenever EMPTYo=0, and VALIDo = !EMPTYo.
REQ-029 FWFT mode: an accepted read advances to the next word in the following cycle.
REQ-030 FWFT mode: a word written to an empty FIFO appears on DATAo one cycle after the write edge.

Reset
REQ-031 RSTi low SHALL asynchronously clear pointers, LEVELo, DATAo, VALIDo, OVFo and UDFo to 0.
REQ-032 During reset, EMPTYo=1, AEMPTYo=1, FULLo=0 and AFULLo=0.
REQ-033 Reset asserted mid-transfer SHALL discard all stored words; the first cycle after release behaves as an empty FIFO.

Configuration
REQ-034 Macro FIFO_FWFT_EN defined SHALL select first-word-fall-through read behaviour (REQ-028..030).
REQ-035 Macro FIFO_FWFT_EN undefined SHALL select standard registered-read behaviour (REQ-026..027); the port list is identical in both modes.

Structure
REQ-036 Package fifo_pkg SHALL hold the default DATA_WIDTH/FIFO_DEPTH constants and the level-width function or localparam.
REQ-037 Storage SHALL be the sub-module fifo_ram: simple dual-port, one write port, one read port, no reset on the array.
REQ-038 Elaboration SHALL fail if FIFO_DEPTH is not a power of 2 or AEMPTY_THRESH >= AFULL_THRESH.

Verification (FIFO_DEPTH=16, DATA_WIDTH=8, defaults)
REQ-039 Write 0x00..0x0F, then read 16 -> data out in order, FULLo=1 after the 16th write, EMPTYo=1 after the 16th read, LEVELo tracks 0..16..0.
REQ-040 Fill to 16, write 0xAA -> write dropped, OVFo=1 next cycle, LEVELo=16; after CLRi -> LEVELo=0, OVFo=0, EMPTYo=1.
REQ-041 Empty FIFO, RDi=1 with WEi=1 DATAi=0x5C -> UDFo=1, LEVELo=1, next read returns 0x5C.
REQ-042 LEVELo=8, WEi=RDi=1 for 20 cycles -> LEVELo stays 8, pointers wrap, data order preserved.
REQ-043 Sweep to levels 2, 3, 13, 14 -> AEMPTYo=1/0 at 2/3, AFULLo=0/1 at 13/14.
REQ-044 With 5 words stored, drive RSTi low mid-burst -> all outputs at reset values; post-release EMPTYo=1; run under both FIFO_FWFT_EN settings to check DATAo/VALIDo timing.
